// File: rtl/mips_pkg.sv
// Shared pipeline definitions used by the fetch and decode stages.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Contents of the IF/ID pipeline register as seen by decode.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
// A bubble clears instr/valid but leaves pc/pc4 untouched.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Next-state select: bubble beats load; neither means hold.
    always_comb begin
        if_id_d = if_id_q;
        if (bubble_i) begin
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
        end else if (load_i) begin
            if_id_d.instr = instr_i;
            if_id_d.pc    = pc_i;
            if_id_d.pc4   = pc4_i;
            if_id_d.valid = 1'b1;
        end
    end

    // Register with asynchronous clear to an empty slot holding a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q.instr <= NOP_INSTR;
            if_id_q.pc    <= 32'h0;
            if_id_q.pc4   <= 32'h0;
            if_id_q.valid <= 1'b0;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign instr_o = if_id_q.instr;
    assign pc_o    = if_id_q.pc;
    assign pc4_o   = if_id_q.pc4;
    assign valid_o = if_id_q.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, IF/ID capture
// and a saturating count of instructions handed to decode.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        fetch_oor_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [31:0] IM_WORDS_W = 32'(IM_WORDS);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic        if_id_load;
    logic        if_id_bubble;
    logic        unused_redirect_low;

    // Redirect targets are forced to a word boundary; the dropped bits are ignored.
    assign unused_redirect_low = ^redirect_pc_i[1:0];

    assign pc_plus4     = pc_q + WORD_BYTES;
    assign im_addr_o    = {2'b00, pc_q[31:2]};
    assign fetch_oor_o  = ({2'b00, pc_q[31:2]} >= IM_WORDS_W);
    assign pc_o         = pc_q;

    // A redirect or flush squashes the word being fetched; a stall freezes it.
    assign if_id_bubble = redirect_i | flush_i;
    assign if_id_load   = ~redirect_i & ~flush_i & ~stall_i;

    // Next PC: redirect wins over stall, otherwise step one word.
    always_comb begin
        pc_d = pc_plus4;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // Count loads into IF/ID, sticking at all-ones.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (if_id_load && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // PC and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (if_id_load),
        .bubble_i (if_id_bubble),
        .instr_i  (im_data_i),
        .pc_i     (pc_q),
        .pc4_i    (pc_plus4),
        .instr_o  (if_id_instr_o),
        .pc_o     (if_id_pc_o),
        .pc4_o    (if_id_pc4_o),
        .valid_o  (if_id_valid_o)
    );

endmodule
